up_dn_cmd_gen: RTL and testbench
================================

# up_dn_cmd_gen

Front-end command generator for the 5-bit up/down counter. Takes three raw push-buttons (up, down, load) and a 5-bit raw switch bank, synchronizes and debounces them, and emits mutually exclusive single-cycle `Load`/`Up`/`Down` strobes plus a registered `IN` load value. Its outputs drive the counter's `IN`/`Load`/`Up`/`Down` inputs directly on the same `CLK`.

## Interface
- `DEB_CYCLES`, 4: consecutive stable synchronized samples required to accept a level change; legal range ≥ 2.
- `REPEAT_DELAY`, 8: cycles a held Up/Down must persist after its first strobe before auto-repeat starts (only with `AUTO_REPEAT_EN`).
- `REPEAT_PERIOD`, 4: cycles between auto-repeat strobes; legal range ≥ 2.
- `CLK`  in  1  single clock. All logic is on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `BTN_UP`, `BTN_DN`, `BTN_LOAD`  in  1 each  raw asynchronous buttons, active-high.
- `SW_IN`  in  5  raw asynchronous load-value switches.
- `IN`  out  5  registered load value, valid in the `Load` cycle.
- `Load`, `Up`, `Down`  out  1 each  registered one-cycle strobes, at most one high per cycle.

## Operation
- Each button and each `SW_IN` bit passes through a 2-flop synchronizer (`s_*`).
- Per button debounce:
  - A counter counts cycles where `s_x != stable_x`.
  - It clears to 0 on any cycle where `s_x == stable_x`.
  - When the count reaches `DEB_CYCLES-1` with a mismatch still present, `stable_x` flips at that edge and the counter clears.
  - Counter width is `$clog2(DEB_CYCLES)`.
- Edge detect: a `stable_x` 0→1 transition is a press event. Releases produce no strobe.
- Priority, same edge: Load > Down > Up. Lower-priority press events in that edge are discarded, not queued. A discarded button produces nothing more until it is released and pressed again.
- On a Load strobe, `IN` takes the synchronized `SW_IN` value at the same edge. `IN` holds until the next Load.
- The block does not observe the counter's `High`/`Low`. Saturation is the counter's job.

## Timing
- Reset: `Load=Up=Down=0`, `IN=5'd0`, all `stable_x=0`, synchronizers and debounce counters 0, repeat FSM `IDLE`.
- Latency: a raw rise sampled at edge 1 appears at `s_x` after edge 2. `stable_x` rises at edge `2+DEB_CYCLES-1`. The strobe is high for exactly the one cycle after that edge. With `DEB_CYCLES=4`, the strobe is high between edges 5 and 6.
- Any bounce (`s_x` returns to `stable_x`) restarts the full `DEB_CYCLES` window.
- Reset mid-operation: all outputs drop immediately, asynchronously. A button still held after `RST` deasserts is treated as a new press and strobes after the normal latency.

## Configuration
- `AUTO_REPEAT_EN` defined: the repeat FSM is compiled in.
  - States: `IDLE`, `HOLD_WAIT`, `REPEAT`.
  - Transitions:
    - An Up or Down strobe latches the direction, clears the timer, and moves `IDLE`→`HOLD_WAIT`.
    - In `HOLD_WAIT`, the timer reaching `REPEAT_DELAY-1` with the latched button still `stable` high emits a strobe and moves to `REPEAT`.
    - In `REPEAT`, a strobe is emitted every `REPEAT_PERIOD` cycles.
    - Release of the latched button (`stable=0`) returns to `IDLE` with no strobe.
    - A Load strobe or an opposite-direction press returns to `IDLE`; that new press's own strobe is still emitted.
  - Repeat strobes obey the same priority. A Load press in the same edge wins and kills the repeat.
- `AUTO_REPEAT_EN` undefined: no FSM or timer logic. Exactly one strobe per press regardless of hold time.

## Test plan
(`DEB_CYCLES=4`, `REPEAT_DELAY=8`, `REPEAT_PERIOD=4` unless noted.)
- Clean press: `BTN_UP` 0→1 before edge 1, held 20 cycles → `Up` high only between edges 5 and 6; `Load` and `Down` stay 0; no second `Up` (macro undefined).
- Bounce: `BTN_DN` toggles 1,0,1,0,1 every 2 cycles then holds 1 → exactly one `Down` strobe, 5 edges after the last 0→1 raw change.
- Load capture: `SW_IN=5'd19`, press `BTN_LOAD`; change `SW_IN` to `5'd7` after the strobe → `Load` for one cycle with `IN=19` in that cycle; `IN` stays 19 afterwards.
- Simultaneous press: `BTN_UP` and `BTN_LOAD` rise together and are held 30 cycles → a single `Load` strobe only; `Up` never asserts until `BTN_UP` is released and re-pressed.
- Auto-repeat (macro defined): first `Up` strobe at cycle t0, `BTN_UP` held → strobes at t0, t0+8, t0+12, t0+16, …; on release, at most one further strobe is possible within the debounce window, then none.
- Reset mid-hold: `RST` low while `BTN_DN` is held in `REPEAT` → all outputs 0 at once and `IN=0`. After `RST` goes high with `BTN_DN` still held → one fresh `Down` strobe at normal latency, then the repeat sequence restarts.

Source files
------------

// File: rtl/up_dn_cmd_gen.sv
// Push-button front end for the 5-bit up/down counter: sync, debounce, prioritised strobes.
// Define AUTO_REPEAT_EN to compile in the hold-to-repeat FSM for Up/Down.
module up_dn_cmd_gen #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_UP,
  input  logic       BTN_DN,
  input  logic       BTN_LOAD,
  input  logic [4:0] SW_IN,
  output logic [4:0] IN,
  output logic       Load,
  output logic       Up,
  output logic       Down
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 2);

  if (DEB_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY < 1) begin : gen_param_check
    $error("up_dn_cmd_gen: illegal parameter value");
  end

  // Button vector order: [0] up, [1] down, [2] load.
  logic [2:0]      btn_meta_q, s_btn_q;
  logic [4:0]      sw_meta_q, s_sw_q;
  logic [2:0]      stable_q, stable_d;
  logic [CntW-1:0] deb_cnt_q [3];
  logic [CntW-1:0] deb_cnt_d [3];
  logic [2:0]      press;
  logic            press_up, press_dn, press_ld;
  logic            up_d, dn_d, ld_d;

  // Flip on the edge where the counter would reach DEB_CYCLES-1; the press strobe
  // is registered on that same edge.
  always_comb begin
    stable_d = stable_q;
    press    = '0;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      if (s_btn_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == CntLast) begin
          stable_d[i] = s_btn_q[i];
          press[i]    = s_btn_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press_ld = press[2];
  assign press_dn = press[1] & ~press[2];
  assign press_up = press[0] & ~press[1] & ~press[2];

`ifdef AUTO_REPEAT_EN
  localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TmrW   = $clog2(TmrMax);

  typedef enum logic [1:0] {StIdle, StHoldWait, StRepeat} rpt_state_e;

  rpt_state_e      state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            dir_q, dir_d;  // 1: down
  logic            held, opp_press, rpt_up, rpt_dn;

  // Use the post-edge debounced level so a button released this edge cannot repeat.
  assign held      = dir_q ? stable_d[1] : stable_d[0];
  assign opp_press = dir_q ? press[0] : press[1];

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    dir_d   = dir_q;
    rpt_up  = 1'b0;
    rpt_dn  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tmr_d = '0;
        if (press_up || press_dn) begin
          state_d = StHoldWait;
          dir_d   = press_dn;
        end
      end
      StHoldWait: begin
        if (press_ld || opp_press || !held) begin
          state_d = StIdle;
        end else if (tmr_q == TmrW'(REPEAT_DELAY - 1)) begin
          state_d = StRepeat;
          tmr_d   = '0;
          rpt_up  = ~dir_q;
          rpt_dn  = dir_q;
        end
      end
      StRepeat: begin
        if (press_ld || opp_press || !held) begin
          state_d = StIdle;
        end else if (tmr_q == TmrW'(REPEAT_PERIOD - 1)) begin
          tmr_d  = '0;
          rpt_up = ~dir_q;
          rpt_dn = dir_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dir_q   <= dir_d;
    end
  end

  // Repeats only fire with no Load or opposite press this edge, so they never collide.
  assign up_d = press_up | rpt_up;
  assign dn_d = press_dn | rpt_dn;
`else
  assign up_d = press_up;
  assign dn_d = press_dn;
`endif

  assign ld_d = press_ld;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      btn_meta_q <= '0;
      s_btn_q    <= '0;
      sw_meta_q  <= '0;
      s_sw_q     <= '0;
      stable_q   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      Load       <= 1'b0;
      Up         <= 1'b0;
      Down       <= 1'b0;
      IN         <= '0;
    end else begin
      btn_meta_q <= {BTN_LOAD, BTN_DN, BTN_UP};
      s_btn_q    <= btn_meta_q;
      sw_meta_q  <= SW_IN;
      s_sw_q     <= sw_meta_q;
      stable_q   <= stable_d;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      Load       <= ld_d;
      Up         <= up_d;
      Down       <= dn_d;
      if (ld_d) IN <= s_sw_q;
    end
  end

endmodule

// File: tb/tb_up_dn_cmd_gen.sv
// Directed bench for up_dn_cmd_gen: each step applies raw buttons then logs outputs 1 time unit
// after the next rising edge, so log index k is "edge k" after the stimulus started.
module tb_up_dn_cmd_gen;

`ifdef AUTO_REPEAT_EN
  localparam int HoldUpCnt  = 3;   // 5, 13, 17 in 20 edges
  localparam int RelUpCnt   = 1;   // repeat at edge 21 before stable falls
  localparam int BounceCnt  = 4;   // 13, 21, 25, 29
  localparam int RstTick    = 17;
  localparam int PostRstCnt = 5;   // 5, 13, 17, 21, 25
`else
  localparam int HoldUpCnt  = 1;
  localparam int RelUpCnt   = 0;
  localparam int BounceCnt  = 1;
  localparam int RstTick    = 5;
  localparam int PostRstCnt = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN_UP, BTN_DN, BTN_LOAD;
  logic [4:0] SW_IN;
  logic [4:0] IN;
  logic       Load, Up, Down;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] up_log, dn_log, ld_log, multi_log;
  logic [4:0]  in_log [64];
  int          idx;

  up_dn_cmd_gen #(
    .DEB_CYCLES   (4),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .BTN_UP  (BTN_UP),
    .BTN_DN  (BTN_DN),
    .BTN_LOAD(BTN_LOAD),
    .SW_IN   (SW_IN),
    .IN      (IN),
    .Load    (Load),
    .Up      (Up),
    .Down    (Down)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    idx       = 0;
    up_log    = '0;
    dn_log    = '0;
    ld_log    = '0;
    multi_log = '0;
    for (int i = 0; i < 64; i++) in_log[i] = '0;
  endtask

  task automatic step(input logic up, input logic dn, input logic ld);
    BTN_UP   = up;
    BTN_DN   = dn;
    BTN_LOAD = ld;
    @(posedge CLK);
    #1;
    idx++;
    up_log[idx]    = Up;
    dn_log[idx]    = Down;
    ld_log[idx]    = Load;
    multi_log[idx] = (int'(Up) + int'(Down) + int'(Load)) > 1;
    in_log[idx]    = IN;
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    clear_log();
  endtask

  function automatic int first_pos(input logic [63:0] v);
    for (int i = 1; i < 64; i++) if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    RST      = 1'b0;
    BTN_UP   = 1'b0;
    BTN_DN   = 1'b0;
    BTN_LOAD = 1'b0;
    SW_IN    = 5'd0;
    clear_log();
    repeat (3) @(posedge CLK);
    #1;
    check_eq("reset_outputs", int'({IN, Load, Up, Down}), 0);
    RST = 1'b1;
    settle();

    // Clean press, then release.
    for (int k = 1; k <= 20; k++) step(1'b1, 1'b0, 1'b0);
    check_eq("clean_up_pos", first_pos(up_log), 5);
    check_eq("clean_up_cnt", $countones(up_log), HoldUpCnt);
    check_eq("clean_dn_cnt", $countones(dn_log), 0);
    check_eq("clean_ld_cnt", $countones(ld_log), 0);
    clear_log();
    for (int k = 1; k <= 10; k++) step(1'b0, 1'b0, 1'b0);
    check_eq("release_up_cnt", $countones(up_log), RelUpCnt);
    settle();

    // Bounce: 1,1,0,0,1,1,0,0 then hold; last raw rise sampled at edge 9.
    for (int k = 1; k <= 30; k++) step(1'b0, (k <= 2) || (k == 5) || (k == 6) || (k >= 9), 1'b0);
    check_eq("bounce_dn_pos", first_pos(dn_log), 13);
    check_eq("bounce_dn_cnt", $countones(dn_log), BounceCnt);
    check_eq("bounce_up_cnt", $countones(up_log), 0);
    settle();

    // Load capture; switches change after the strobe.
    SW_IN = 5'd19;
    for (int k = 1; k <= 15; k++) begin
      if (k >= 6) SW_IN = 5'd7;
      step(1'b0, 1'b0, 1'b1);
    end
    check_eq("load_pos", first_pos(ld_log), 5);
    check_eq("load_cnt", $countones(ld_log), 1);
    check_eq("load_in_before", int'(in_log[4]), 0);
    check_eq("load_in_at", int'(in_log[5]), 19);
    check_eq("load_in_hold", int'(in_log[15]), 19);
    settle();

    // Simultaneous Up + Load: Load wins, Up is discarded until re-pressed.
    for (int k = 1; k <= 30; k++) step(1'b1, 1'b0, 1'b1);
    check_eq("simul_ld_pos", first_pos(ld_log), 5);
    check_eq("simul_ld_cnt", $countones(ld_log), 1);
    check_eq("simul_up_cnt", $countones(up_log), 0);
    check_eq("simul_in", int'(in_log[5]), 7);
    clear_log();
    for (int k = 1; k <= 10; k++) step(1'b0, 1'b0, 1'b0);
    check_eq("simul_rel_cnt", $countones(up_log | dn_log | ld_log), 0);
    clear_log();
    for (int k = 1; k <= 10; k++) step(1'b1, 1'b0, 1'b0);
    check_eq("repress_up_pos", first_pos(up_log), 5);
    check_eq("repress_up_cnt", $countones(up_log), 1);
    settle();

    // Reset while Down is strobing; IN holds 7 beforehand.
    for (int k = 1; k <= RstTick; k++) step(1'b0, 1'b1, 1'b0);
    check_eq("pre_rst_down", int'(Down), 1);
    check_eq("pre_rst_in", int'(IN), 7);
    #2;
    RST = 1'b0;
    #1;
    check_eq("rst_async_outputs", int'({IN, Load, Up, Down}), 0);
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_held_outputs", int'({IN, Load, Up, Down}), 0);
    RST = 1'b1;
    clear_log();
    for (int k = 1; k <= 25; k++) step(1'b0, 1'b1, 1'b0);
    check_eq("post_rst_dn_pos", first_pos(dn_log), 5);
    check_eq("post_rst_dn_cnt", $countones(dn_log), PostRstCnt);
    check_eq("post_rst_ld_cnt", $countones(ld_log), 0);
    check_eq("post_rst_multi", $countones(multi_log), 0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
